memory_stage: RTL and testbench

Pipeline MEM stage of the 16-bit encryption CPU, directly downstream of `execute`. It consumes the execute→memory pipeline outputs and drives a variable-latency data-memory port through a request/ready handshake. It stalls the pipeline while an access is outstanding and aborts hung accesses after a programmable timeout. It registers results into the memory→writeback pipeline register.

---
 rtl/memory_stage.sv | 146 ++++++++++++++
 tb/tb_memory_stage.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// rtl/memory_stage.sv - pipeline MEM stage with stalling data-memory handshake and access timeout
module memory_stage #(
   parameter int DATA_W  = 16,
   parameter int RD_W    = 4,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              regWriteM,
   input  logic              memWriteM,
   input  logic [1:0]        resultSrcM,
   input  logic [DATA_W-1:0] PCPlus2M,
   input  logic [DATA_W-1:0] aluResM,
   input  logic [DATA_W-1:0] writeDataM,
   input  logic [RD_W-1:0]   RdM,
   output logic              memReq,
   output logic              memWe,
   output logic [DATA_W-1:0] memAddr,
   output logic [DATA_W-1:0] memWData,
   input  logic [DATA_W-1:0] memRData,
   input  logic              memReady,
   output logic              stallM,
   output logic              regWriteW,
   output logic [1:0]        resultSrcW,
   output logic [DATA_W-1:0] aluResW,
   output logic [DATA_W-1:0] readDataW,
   output logic [DATA_W-1:0] PCPlus2W,
   output logic [RD_W-1:0]   RdW,
   output logic              memErr,
   output logic [DATA_W-1:0] memErrAddr
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;
   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   logic [0:0]        state_q, state_d;
   logic [7:0]        wait_cnt_q, wait_cnt_d;
   logic              reg_write_q, reg_write_d;
   logic [1:0]        result_src_q, result_src_d;
   logic [DATA_W-1:0] alu_res_q, alu_res_d;
   logic [DATA_W-1:0] read_data_q, read_data_d;
   logic [DATA_W-1:0] pc_plus2_q, pc_plus2_d;
   logic [RD_W-1:0]   rd_q, rd_d;
   logic              mem_err_q, mem_err_d;
   logic [DATA_W-1:0] mem_err_addr_q, mem_err_addr_d;

   logic is_mem;
   logic abort;
   logic retire;

   // Request side is purely combinational so a zero-wait memory costs no cycle
   always_comb begin
      is_mem   = memWriteM | (resultSrcM == 2'b01);
      memReq   = rst & is_mem;
      memWe    = memReq & memWriteM;
      memAddr  = aluResM;
      memWData = writeDataM;
      abort    = is_mem & ~memReady & (state_q == S_WAIT) & (wait_cnt_q == LAST_WAIT);
      // The instruction leaves the stage when it needs no memory or its access completes
      retire   = ~is_mem | memReady;
      stallM   = rst & is_mem & ~memReady & ~abort;
   end

   // Next-state for the access FSM, the W register and the sticky error capture
   always_comb begin
      state_d        = state_q;
      wait_cnt_d     = wait_cnt_q;
      mem_err_d      = mem_err_q;
      mem_err_addr_d = mem_err_addr_q;

      if (retire || abort) begin
         state_d    = S_IDLE;
         wait_cnt_d = 8'd0;
      end else if (state_q == S_IDLE) begin
         state_d    = S_WAIT;
         wait_cnt_d = 8'd1;
      end else begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end

      if (abort) begin
         mem_err_d = 1'b1;
         // Keep the first faulting address so a later hang cannot hide the original cause
         if (!mem_err_q) begin
            mem_err_addr_d = aluResM;
         end
      end

      if (retire) begin
         reg_write_d  = regWriteM;
         result_src_d = resultSrcM;
         alu_res_d    = aluResM;
         read_data_d  = memRData;
         pc_plus2_d   = PCPlus2M;
         rd_d         = RdM;
      end else begin
         reg_write_d  = 1'b0;
         result_src_d = 2'b00;
         alu_res_d    = '0;
         read_data_d  = '0;
         pc_plus2_d   = '0;
         rd_d         = '0;
      end
   end

   // State and pipeline register update, cleared asynchronously on reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= S_IDLE;
         wait_cnt_q     <= 8'd0;
         reg_write_q    <= 1'b0;
         result_src_q   <= 2'b00;
         alu_res_q      <= '0;
         read_data_q    <= '0;
         pc_plus2_q     <= '0;
         rd_q           <= '0;
         mem_err_q      <= 1'b0;
         mem_err_addr_q <= '0;
      end else begin
         state_q        <= state_d;
         wait_cnt_q     <= wait_cnt_d;
         reg_write_q    <= reg_write_d;
         result_src_q   <= result_src_d;
         alu_res_q      <= alu_res_d;
         read_data_q    <= read_data_d;
         pc_plus2_q     <= pc_plus2_d;
         rd_q           <= rd_d;
         mem_err_q      <= mem_err_d;
         mem_err_addr_q <= mem_err_addr_d;
      end
   end

   // Registered outputs toward writeback
   always_comb begin
      regWriteW  = reg_write_q;
      resultSrcW = result_src_q;
      aluResW    = alu_res_q;
      readDataW  = read_data_q;
      PCPlus2W   = pc_plus2_q;
      RdW        = rd_q;
      memErr     = mem_err_q;
      memErrAddr = mem_err_addr_q;
   end

endmodule

// File: tb/tb_memory_stage.sv
// tb/tb_memory_stage.sv - scoreboard bench for memory_stage
module tb_memory_stage;

   typedef struct {
      logic        rw;
      logic [1:0]  rs;
      logic [15:0] alu;
      logic [15:0] rdata;
      logic [15:0] pc;
      logic [3:0]  rd;
      logic        chk_rdata;
   } w_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        regWriteM = 1'b0, memWriteM = 1'b0;
   logic [1:0]  resultSrcM = 2'b00;
   logic [15:0] PCPlus2M = '0, aluResM = '0, writeDataM = '0, memRData = '0;
   logic [3:0]  RdM = '0;
   logic        memReady = 1'b0;
   logic        memReq, memWe, stallM, regWriteW, memErr;
   logic [15:0] memAddr, memWData, aluResW, readDataW, PCPlus2W, memErrAddr;
   logic [1:0]  resultSrcW;
   logic [3:0]  RdW;

   int n_checks = 0;
   int n_errors = 0;
   w_t sb[$];
   w_t bubble = '{1'b0, 2'b00, 16'h0, 16'h0, 16'h0, 4'h0, 1'b1};

   memory_stage #(.DATA_W(16), .RD_W(4), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .regWriteM(regWriteM), .memWriteM(memWriteM), .resultSrcM(resultSrcM),
      .PCPlus2M(PCPlus2M), .aluResM(aluResM), .writeDataM(writeDataM), .RdM(RdM),
      .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
      .memRData(memRData), .memReady(memReady), .stallM(stallM),
      .regWriteW(regWriteW), .resultSrcW(resultSrcW), .aluResW(aluResW),
      .readDataW(readDataW), .PCPlus2W(PCPlus2W), .RdW(RdW),
      .memErr(memErr), .memErrAddr(memErrAddr)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic rw, input logic mw, input logic [1:0] rs,
                        input logic [15:0] pc, input logic [15:0] alu,
                        input logic [15:0] wd, input logic [3:0] rd,
                        input logic rdy, input logic [15:0] rdata);
      regWriteM = rw; memWriteM = mw; resultSrcM = rs; PCPlus2M = pc;
      aluResM = alu; writeDataM = wd; RdM = rd; memReady = rdy; memRData = rdata;
   endtask

   // One pipeline cycle: check request-side outputs mid-cycle, push the expected W entry,
   // then pop and compare it right after the edge.
   task automatic step(input logic e_stall, input logic e_req, input logic e_we, input w_t e);
      w_t g;
      @(negedge clk);
      chk("stallM", stallM, e_stall);
      chk("memReq", memReq, e_req);
      chk("memWe", memWe, e_we);
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         g = sb.pop_front();
         chk("regWriteW", regWriteW, g.rw);
         chk("resultSrcW", resultSrcW, g.rs);
         chk("aluResW", aluResW, g.alu);
         chk("PCPlus2W", PCPlus2W, g.pc);
         chk("RdW", RdW, g.rd);
         if (g.chk_rdata) chk("readDataW", readDataW, g.rdata);
      end
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_memReq", memReq, 0);
      chk("rst_stallM", stallM, 0);
      chk("rst_regWriteW", regWriteW, 0);
      chk("rst_aluResW", aluResW, 0);
      chk("rst_memErr", memErr, 0);
      chk("rst_memErrAddr", memErrAddr, 0);
      @(posedge clk); #1;
      rst = 1'b1;

      // ALU passthrough; memReady pulse is ignored without a request
      drive(1, 0, 2'b00, 16'h0102, 16'h0001, 16'h0, 4'hC, 1, 16'h5555);
      step(0, 0, 0, '{1'b1, 2'b00, 16'h0001, 16'h0, 16'h0102, 4'hC, 1'b0});

      // Two back-to-back zero-wait loads
      drive(1, 0, 2'b01, 16'h0200, 16'h0040, 16'h0, 4'h3, 1, 16'hBEEF);
      #1 chk("memAddr_ld", memAddr, 16'h0040);
      step(0, 1, 0, '{1'b1, 2'b01, 16'h0040, 16'hBEEF, 16'h0200, 4'h3, 1'b1});
      drive(1, 0, 2'b01, 16'h0202, 16'h0042, 16'h0, 4'h4, 1, 16'hCAFE);
      step(0, 1, 0, '{1'b1, 2'b01, 16'h0042, 16'hCAFE, 16'h0202, 4'h4, 1'b1});

      // Store with three wait cycles
      drive(0, 1, 2'b00, 16'h0300, 16'h0050, 16'h1234, 4'h0, 0, 16'h0);
      #1 chk("memWData_st", memWData, 16'h1234);
      for (int i = 0; i < 3; i++) step(1, 1, 1, bubble);
      memReady = 1'b1;
      step(0, 1, 1, '{1'b0, 2'b00, 16'h0050, 16'h0, 16'h0300, 4'h0, 1'b0});

      // Hung load at 0x0080 aborts after four request cycles
      drive(1, 0, 2'b01, 16'h0400, 16'h0080, 16'h0, 4'h7, 0, 16'h0);
      for (int i = 0; i < 3; i++) step(1, 1, 0, bubble);
      chk("memErr_pre", memErr, 0);
      step(0, 1, 0, bubble);
      chk("memErr_1", memErr, 1);
      chk("memErrAddr_1", memErrAddr, 16'h0080);

      // Second hang keeps the first address
      drive(1, 0, 2'b01, 16'h0500, 16'h0090, 16'h0, 4'h8, 0, 16'h0);
      for (int i = 0; i < 3; i++) step(1, 1, 0, bubble);
      step(0, 1, 0, bubble);
      chk("memErr_2", memErr, 1);
      chk("memErrAddr_2", memErrAddr, 16'h0080);

      // Following ALU op completes normally
      drive(1, 0, 2'b00, 16'h0600, 16'hA5A5, 16'h0, 4'h9, 0, 16'h0);
      step(0, 0, 0, '{1'b1, 2'b00, 16'hA5A5, 16'h0, 16'h0600, 4'h9, 1'b0});

      // Reset in the middle of a waiting access
      drive(1, 0, 2'b01, 16'h0700, 16'h00A0, 16'h0, 4'h2, 0, 16'h0);
      step(1, 1, 0, bubble);
      #2;
      chk("midrst_req_before", memReq, 1);
      rst = 1'b0;
      #1;
      chk("midrst_memReq", memReq, 0);
      chk("midrst_stallM", stallM, 0);
      chk("midrst_regWriteW", regWriteW, 0);
      chk("midrst_memErr", memErr, 0);
      chk("midrst_memErrAddr", memErrAddr, 0);
      @(posedge clk); #1;
      rst = 1'b1;

      // After release the stage is idle: hang needs a full four request cycles again
      drive(1, 0, 2'b01, 16'h0800, 16'h00B0, 16'h0, 4'h5, 0, 16'h0);
      for (int i = 0; i < 3; i++) step(1, 1, 0, bubble);
      step(0, 1, 0, bubble);
      chk("memErrAddr_3", memErrAddr, 16'h00B0);

      // Zero-wait load straight after the abort
      drive(1, 0, 2'b01, 16'h0900, 16'h00C0, 16'h0, 4'h6, 1, 16'h1357);
      step(0, 1, 0, '{1'b1, 2'b01, 16'h00C0, 16'h1357, 16'h0900, 4'h6, 1'b1});

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
